comp_pipe: RTL and testbench

Parametrised, two-stage pipelined magnitude comparator for unsigned W-bit operands, with a valid/ready handshake. It produces lt/eq/gt flags, the absolute difference, and the larger and smaller operands. It sits at the front of the FP adder datapath: exponent compare, operand swap and alignment-shift generation, with back-pressure from the mantissa aligner. The arithmetic is two's-complement subtract then conditional negate, built from the existing adder cells.

---
 rtl/comp_pipe_if.sv | 31 +++
 rtl/comp_pipe.sv | 130 +++++++++++++
 tb/tb_comp_pipe.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/comp_pipe_if.sv
// comp_pipe_if: operand/result bundle with valid/ready handshake for comp_pipe.
// The master side presents operand pairs and accepts results; the slave side is the comparator.
interface comp_pipe_if #(
    parameter int unsigned W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic         a_lt_b;
    logic         a_eq_b;
    logic         a_gt_b;
    logic [W-1:0] abs_diff;
    logic [W-1:0] max_val;
    logic [W-1:0] min_val;
    logic         sat;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, a_lt_b, a_eq_b, a_gt_b,
               abs_diff, max_val, min_val, sat
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, a_lt_b, a_eq_b, a_gt_b,
               abs_diff, max_val, min_val, sat
    );
endinterface

// File: rtl/comp_pipe.sv
// comp_pipe: two-stage pipelined unsigned magnitude comparator (flags, |A-B|, max/min).
// Define COMP_SAT_EN to clamp abs_diff at SAT and report the clamp on sat.
module comp_pipe #(
    parameter int unsigned W   = 8,
    parameter int unsigned SAT = 24,
    parameter real         T   = 0.0
) (
    input logic        clk,
    input logic        rst,
    comp_pipe_if.slave bus
);
    localparam int unsigned WS = W + 1;

    // Elaboration-time parameter sanity
    if (W < 2) begin : g_bad_w
        $error("comp_pipe: W must be at least 2");
    end
    if (SAT < 1 || 64'(SAT) > ((64'(1) << W) - 64'(1))) begin : g_bad_sat
        $error("comp_pipe: SAT must lie in 1 .. 2**W-1");
    end
    if (T < 0.0) begin : g_bad_t
        $error("comp_pipe: T must be non-negative");
    end

    logic          v1;
    logic          v2;
    logic          adv1;
    logic          adv2;
    logic [WS-1:0] sum;
    logic [W-1:0]  s1_s;
    logic          s1_c;
    logic [W-1:0]  s1_a;
    logic [W-1:0]  s1_b;

    logic          ne;
    logic          lt_n;
    logic          eq_n;
    logic          gt_n;
    logic [W-1:0]  d_n;
    logic [W-1:0]  diff_n;
    logic          sat_n;
    logic [W-1:0]  max_n;
    logic [W-1:0]  min_n;

    logic          lt_q;
    logic          eq_q;
    logic          gt_q;
    logic [W-1:0]  diff_q;
    logic [W-1:0]  max_q;
    logic [W-1:0]  min_q;
    logic          sat_q;

    // A stage may load when it is empty or its successor is taking its content
    assign adv2         = ~v2 | bus.out_ready;
    assign adv1         = ~v1 | adv2;
    assign bus.in_ready = adv1;

    // a - b as a + ~b + 1; carry-out set means a >= b
    assign sum = {1'b0, bus.a} + {1'b0, ~bus.b} + WS'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            s1_s <= '0;
            s1_c <= 1'b0;
            s1_a <= '0;
            s1_b <= '0;
        end else if (adv1) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                s1_s <= sum[W-1:0];
                s1_c <= sum[W];
                s1_a <= bus.a;
                s1_b <= bus.b;
            end
        end
    end

    // Flag decode, conditional negate and operand swap from the S1 difference
    always_comb begin
        ne     = |s1_s;
        eq_n   = ~ne;
        gt_n   = ne & s1_c;
        lt_n   = ne & ~s1_c;
        d_n    = lt_n ? (~s1_s + W'(1)) : s1_s;
        max_n  = lt_n ? s1_b : s1_a;
        min_n  = lt_n ? s1_a : s1_b;
        diff_n = d_n;
        sat_n  = 1'b0;
`ifdef COMP_SAT_EN
        if (d_n > W'(SAT)) begin
            diff_n = W'(SAT);
            sat_n  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2     <= 1'b0;
            lt_q   <= 1'b0;
            eq_q   <= 1'b0;
            gt_q   <= 1'b0;
            diff_q <= '0;
            max_q  <= '0;
            min_q  <= '0;
            sat_q  <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                lt_q   <= lt_n;
                eq_q   <= eq_n;
                gt_q   <= gt_n;
                diff_q <= diff_n;
                max_q  <= max_n;
                min_q  <= min_n;
                sat_q  <= sat_n;
            end
        end
    end

    assign bus.out_valid = v2;
    assign bus.a_lt_b    = lt_q;
    assign bus.a_eq_b    = eq_q;
    assign bus.a_gt_b    = gt_q;
    assign bus.abs_diff  = diff_q;
    assign bus.max_val   = max_q;
    assign bus.min_val   = min_q;
    assign bus.sat       = sat_q;
endmodule

// File: tb/tb_comp_pipe.sv
// tb_comp_pipe: scoreboard bench for comp_pipe (W=8, SAT=24); driver pushes expected
// results on accept, a negedge monitor pops and compares on every output transfer.
module tb_comp_pipe;
    localparam int unsigned W = 8;

    typedef struct packed {
        logic         lt;
        logic         eq;
        logic         gt;
        logic [W-1:0] diff;
        logic [W-1:0] mx;
        logic [W-1:0] mn;
        logic         sat;
    } res_t;

    logic clk = 1'b0;
    logic rst;

    comp_pipe_if #(.W(W)) bus ();

    comp_pipe #(.W(W), .SAT(24), .T(0.0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    res_t exp_q[$];
    res_t mon_g;
    res_t mon_e;
    res_t snap;
    int   checks = 0;
    int   passed = 0;
    int   stalls = 0;

    task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    function automatic res_t mk(input logic lt, input logic eq, input logic gt,
                                input logic [W-1:0] diff, input logic [W-1:0] mx,
                                input logic [W-1:0] mn, input logic sat);
        res_t r;
        r.lt = lt; r.eq = eq; r.gt = gt;
        r.diff = diff; r.mx = mx; r.mn = mn; r.sat = sat;
        return r;
    endfunction

    // Reference built from relational compares, independent of the subtract/negate datapath
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t r;
        r.lt   = (a < b);
        r.eq   = (a == b);
        r.gt   = (a > b);
        r.diff = (a > b) ? W'(a - b) : W'(b - a);
        r.mx   = (a >= b) ? a : b;
        r.mn   = (a >= b) ? b : a;
        r.sat  = 1'b0;
`ifdef COMP_SAT_EN
        if (r.diff > W'(24)) begin
            r.diff = W'(24);
            r.sat  = 1'b1;
        end
`endif
        return r;
    endfunction

    function automatic res_t observed();
        res_t r;
        r.lt = bus.a_lt_b; r.eq = bus.a_eq_b; r.gt = bus.a_gt_b;
        r.diff = bus.abs_diff; r.mx = bus.max_val; r.mn = bus.min_val; r.sat = bus.sat;
        return r;
    endfunction

    // Monitor: one compare per output transfer
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            mon_g = observed();
            chk("scoreboard_nonempty", exp_q.size() > 0, 64'(exp_q.size()), 64'(1));
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("result", mon_g == mon_e, 64'(mon_g), 64'(mon_e));
                chk("one_hot_flags", $countones({mon_g.lt, mon_g.eq, mon_g.gt}) == 1,
                    64'({mon_g.lt, mon_g.eq, mon_g.gt}), 64'(0));
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input res_t e);
        bit accepted = 1'b0;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        for (int n = 0; n < 200 && !accepted; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(e);
                accepted = 1'b1;
            end else begin
                stalls++;
            end
        end
        chk("accept", accepted, 64'(accepted), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
        chk("drain", exp_q.size() == 0, 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", bus.out_valid == 1'b0, 64'(bus.out_valid), 64'(0));
        chk("reset_outputs", observed() == '0, 64'(observed()), 64'(0));
        chk("reset_in_ready", bus.in_ready == 1'b1, 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;

        // Single pair and two-cycle latency
        send(8'h80, 8'h7F, mk(1'b0, 1'b0, 1'b1, 8'd1, 8'h80, 8'h7F, 1'b0));
        idle();
        @(negedge clk);
        chk("latency_n1", bus.out_valid == 1'b0, 64'(bus.out_valid), 64'(0));
        @(negedge clk);
        chk("latency_n2", bus.out_valid == 1'b1, 64'(bus.out_valid), 64'(1));
        @(posedge clk);
        #1;

        // Equality at both ends of the range, then less-than cases
        send(8'hFF, 8'hFF, mk(1'b0, 1'b1, 1'b0, 8'd0, 8'hFF, 8'hFF, 1'b0));
        send(8'h00, 8'h00, mk(1'b0, 1'b1, 1'b0, 8'd0, 8'h00, 8'h00, 1'b0));
`ifdef COMP_SAT_EN
        send(8'd3, 8'd200, mk(1'b1, 1'b0, 1'b0, 8'd24, 8'd200, 8'd3, 1'b1));
        send(8'd0, 8'd255, mk(1'b1, 1'b0, 1'b0, 8'd24, 8'd255, 8'd0, 1'b1));
`else
        send(8'd3, 8'd200, mk(1'b1, 1'b0, 1'b0, 8'd197, 8'd200, 8'd3, 1'b0));
        send(8'd0, 8'd255, mk(1'b1, 1'b0, 1'b0, 8'd255, 8'd255, 8'd0, 1'b0));
`endif
        idle();
        drain();

        // Back-pressure: fill the pipe, hold, then release
        bus.out_ready = 1'b0;
        fork
            begin
                send(8'd1, 8'd2, mk(1'b1, 1'b0, 1'b0, 8'd1, 8'd2, 8'd1, 1'b0));
                send(8'd5, 8'd5, mk(1'b0, 1'b1, 1'b0, 8'd0, 8'd5, 8'd5, 1'b0));
                send(8'd9, 8'd4, mk(1'b0, 1'b0, 1'b1, 8'd5, 8'd9, 8'd4, 1'b0));
                send(8'd7, 8'd0, mk(1'b0, 1'b0, 1'b1, 8'd7, 8'd7, 8'd0, 1'b0));
                idle();
            end
            begin
                repeat (3) @(negedge clk);
                chk("stall_in_ready", bus.in_ready == 1'b0, 64'(bus.in_ready), 64'(0));
                chk("stall_out_valid", bus.out_valid == 1'b1, 64'(bus.out_valid), 64'(1));
                snap = observed();
                repeat (2) begin
                    @(negedge clk);
                    chk("stall_stable", observed() == snap, 64'(observed()), 64'(snap));
                    chk("stall_in_ready_held", bus.in_ready == 1'b0, 64'(bus.in_ready), 64'(0));
                end
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    chk("release_back_to_back", bus.out_valid == 1'b1, 64'(bus.out_valid), 64'(1));
                end
            end
        join
        drain();

        // Full-rate random stream
        stalls = 0;
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            send(ra, rb, model(ra, rb));
        end
        idle();
        chk("full_rate_in_ready", stalls == 0, 64'(stalls), 64'(0));
        drain();

        // Reset with two pairs in flight
        bus.out_ready = 1'b0;
        send(8'd1, 8'd2, model(8'd1, 8'd2));
        send(8'd200, 8'd100, model(8'd200, 8'd100));
        idle();
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", bus.out_valid == 1'b0, 64'(bus.out_valid), 64'(0));
        chk("flush_outputs", observed() == '0, 64'(observed()), 64'(0));
        chk("flush_in_ready", bus.in_ready == 1'b1, 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        send(8'd10, 8'd3, mk(1'b0, 1'b0, 1'b1, 8'd7, 8'd10, 8'd3, 1'b0));
        idle();
        drain();
        repeat (3) @(negedge clk);
        chk("no_stray_output", bus.out_valid == 1'b0, 64'(bus.out_valid), 64'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
